// File: rtl/tl45_load_scoreboard_if.sv
// Register-read hazard bundle between the RR stage and the load scoreboard.
// The master side is RR and the writeback port; the slave side is the scoreboard.
interface tl45_load_scoreboard_if #(
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          i_pipe_stall;
  logic          i_pipe_flush;
  logic          i_valid;
  logic [4:0]    i_opcode;
  logic          i_ri;
  logic [3:0]    i_dr;
  logic [3:0]    i_sr1;
  logic [3:0]    i_sr2;
  logic          i_wb_valid;
  logic [3:0]    i_wb_reg;
  logic          o_pipe_stall;
  logic          o_hazard;
  logic [15:0]   o_busy;
  logic [CW-1:0] o_outstanding;
  logic          o_deadlock;

  modport master (
    output i_pipe_stall, i_pipe_flush, i_valid, i_opcode, i_ri,
    output i_dr, i_sr1, i_sr2, i_wb_valid, i_wb_reg,
    input  o_pipe_stall, o_hazard, o_busy, o_outstanding, o_deadlock
  );

  modport slave (
    input  i_pipe_stall, i_pipe_flush, i_valid, i_opcode, i_ri,
    input  i_dr, i_sr1, i_sr2, i_wb_valid, i_wb_reg,
    output o_pipe_stall, o_hazard, o_busy, o_outstanding, o_deadlock
  );
endinterface

// File: rtl/tl45_load_scoreboard.sv
// Load scoreboard for the RR stage: tracks pending long-latency destinations
// and stalls RR on RAW/WAW/capacity hazards, with a sticky deadlock watchdog.
module tl45_load_scoreboard #(
  parameter logic [4:0] LOAD_OPCODE     = 5'h14,
  parameter logic [4:0] BRANCH_OPCODE   = 5'h0C,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         DEADLOCK_CYCLES = 256
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  tl45_load_scoreboard_if.slave sb
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW = $clog2(DEADLOCK_CYCLES + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [DW-1:0] DL_MAX  = DW'(DEADLOCK_CYCLES);

  logic [15:0]   busy_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dl_q;
  logic          dead_q;

  logic          is_load;
  logic          raw;
  logic          waw;
  logic          full;
  logic          hazard;
  logic          accept;
  logic          set_en;
  logic          clr_en;
  logic [15:0]   set_mask;
  logic [15:0]   clr_mask;
  logic [15:0]   busy_d;
  logic [CW-1:0] cnt_d;

  assign is_load = (sb.i_opcode == LOAD_OPCODE) && (sb.i_dr != 4'd0);
  assign raw     = busy_q[sb.i_sr1] | (~sb.i_ri & busy_q[sb.i_sr2]);
  assign waw     = (sb.i_opcode != BRANCH_OPCODE) & busy_q[sb.i_dr];
  assign full    = is_load & (cnt_q == MAX_CNT);
  assign hazard  = sb.i_valid & ~sb.i_pipe_flush & (raw | waw | full);
  assign accept  = sb.i_valid & ~hazard & ~sb.i_pipe_stall
                 & ~sb.i_pipe_flush;
  assign set_en  = accept & is_load;
  assign clr_en  = sb.i_wb_valid & busy_q[sb.i_wb_reg];

  // Set is applied after clear so a same-register collision keeps the bit.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[sb.i_dr] = 1'b1;
    if (clr_en) clr_mask[sb.i_wb_reg] = 1'b1;
    busy_d = ((busy_q & ~clr_mask) | set_mask) & 16'hFFFE;
    unique case (1'b1)
      set_en & ~clr_en: cnt_d = cnt_q + 1'b1;
      clr_en & ~set_en: cnt_d = cnt_q - 1'b1;
      default:          cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      dl_q   <= '0;
      dead_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (hazard) begin
        if (dl_q != DL_MAX) dl_q <= dl_q + 1'b1;
        if (dl_q == DL_MAX - 1'b1) dead_q <= 1'b1;
      end else begin
        dl_q <= '0;
      end
    end
  end

  assign sb.o_hazard      = hazard;
  assign sb.o_pipe_stall  = sb.i_pipe_stall | hazard;
  assign sb.o_busy        = busy_q;
  assign sb.o_outstanding = cnt_q;
  assign sb.o_deadlock    = dead_q;
endmodule

// File: tb/tb_tl45_load_scoreboard.sv
// Bench for tl45_load_scoreboard: directed vector table, deadlock/reset
// sequence, then random traffic against a pending-register queue model.
module tb_tl45_load_scoreboard;
  localparam logic [4:0] LD = 5'h14;
  localparam logic [4:0] BR = 5'h0C;
  localparam logic [4:0] AD = 5'h01;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tl45_load_scoreboard_if #(.MAX_OUTSTANDING(4)) bus ();

  tl45_load_scoreboard #(
    .LOAD_OPCODE(LD),
    .BRANCH_OPCODE(BR),
    .MAX_OUTSTANDING(4),
    .DEADLOCK_CYCLES(256)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .sb(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [4:0]  op;
    logic        ri;
    logic [3:0]  dr;
    logic [3:0]  sr1;
    logic [3:0]  sr2;
    logic        wbv;
    logic [3:0]  wbr;
    logic        ps;
    logic        fl;
    logic        eh;
    logic [15:0] eb;
    logic [2:0]  eo;
  } vec_t;

  vec_t tbl[26];

  int q_pend[$];
  int dl_run;
  bit m_dead;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic [4:0] op, logic ri,
                              logic [3:0] dr, logic [3:0] s1,
                              logic [3:0] s2, logic wbv, logic [3:0] wbr,
                              logic ps, logic fl, logic eh,
                              logic [15:0] eb, logic [2:0] eo);
    vec_t t;
    t.valid = v; t.op = op; t.ri = ri; t.dr = dr;
    t.sr1 = s1; t.sr2 = s2; t.wbv = wbv; t.wbr = wbr;
    t.ps = ps; t.fl = fl; t.eh = eh; t.eb = eb; t.eo = eo;
    return t;
  endfunction

  task automatic drive(vec_t t);
    bus.i_valid      = t.valid;
    bus.i_opcode     = t.op;
    bus.i_ri         = t.ri;
    bus.i_dr         = t.dr;
    bus.i_sr1        = t.sr1;
    bus.i_sr2        = t.sr2;
    bus.i_wb_valid   = t.wbv;
    bus.i_wb_reg     = t.wbr;
    bus.i_pipe_stall = t.ps;
    bus.i_pipe_flush = t.fl;
  endtask

  function automatic bit pend(int r);
    foreach (q_pend[i]) if (q_pend[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] m_busy();
    logic [15:0] b;
    b = '0;
    foreach (q_pend[i]) b[q_pend[i]] = 1'b1;
    return b;
  endfunction

  function automatic bit m_hazard(vec_t t);
    bit h;
    h = pend(int'(t.sr1)) || (!t.ri && pend(int'(t.sr2)));
    h = h || (t.op != BR && pend(int'(t.dr)));
    h = h || (t.op == LD && t.dr != 0 && q_pend.size() == 4);
    return t.valid && !t.fl && h;
  endfunction

  task automatic m_step(vec_t t, bit h);
    bit acc;
    bit setr;
    acc  = t.valid && !h && !t.ps && !t.fl;
    setr = acc && t.op == LD && t.dr != 0;
    if (t.wbv && pend(int'(t.wbr)) && !(setr && t.dr == t.wbr)) begin
      foreach (q_pend[i])
        if (q_pend[i] == int'(t.wbr)) begin
          q_pend.delete(i);
          break;
        end
    end
    if (setr && !pend(int'(t.dr))) q_pend.push_back(int'(t.dr));
    if (h) begin
      if (dl_run < 256) dl_run++;
      if (dl_run == 256) m_dead = 1'b1;
    end else begin
      dl_run = 0;
    end
  endtask

  initial begin
    vec_t t;
    bit   h;
    total = 0;
    bad   = 0;
    dl_run = 0;
    m_dead = 1'b0;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // load R3, RAW on R3 until writeback, then accepted
    tbl[0]  = mk(1, LD, 1, 3, 0, 0, 0, 0, 0, 0, 0, 16'h0008, 1);
    tbl[1]  = mk(1, AD, 0, 4, 3, 5, 0, 0, 0, 0, 1, 16'h0008, 1);
    tbl[2]  = mk(1, AD, 0, 4, 3, 5, 1, 3, 0, 0, 1, 16'h0000, 0);
    tbl[3]  = mk(1, AD, 0, 4, 3, 5, 0, 0, 0, 0, 0, 16'h0000, 0);
    // load R0 sets nothing; R0 reader never stalls
    tbl[4]  = mk(1, LD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    tbl[5]  = mk(1, AD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
    // fill to capacity, FULL stall, drain one
    tbl[6]  = mk(1, LD, 1, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0002, 1);
    tbl[7]  = mk(1, LD, 1, 2, 0, 0, 0, 0, 0, 0, 0, 16'h0006, 2);
    tbl[8]  = mk(1, LD, 1, 3, 0, 0, 0, 0, 0, 0, 0, 16'h000E, 3);
    tbl[9]  = mk(1, LD, 1, 4, 0, 0, 0, 0, 0, 0, 0, 16'h001E, 4);
    tbl[10] = mk(1, LD, 1, 5, 0, 0, 0, 0, 0, 0, 1, 16'h001E, 4);
    tbl[11] = mk(1, LD, 1, 5, 0, 0, 1, 2, 0, 0, 1, 16'h001A, 3);
    tbl[12] = mk(1, LD, 1, 5, 0, 0, 0, 0, 0, 0, 0, 16'h003A, 4);
    // branch DR not a destination; flush suppresses hazard and set
    tbl[13] = mk(1, BR, 1, 3, 0, 0, 0, 0, 0, 0, 0, 16'h003A, 4);
    tbl[14] = mk(1, AD, 0, 7, 1, 0, 0, 0, 0, 1, 0, 16'h003A, 4);
    tbl[15] = mk(1, LD, 1, 6, 0, 0, 0, 0, 0, 1, 0, 16'h003A, 4);
    tbl[16] = mk(1, AD, 1, 7, 0, 0, 0, 0, 1, 0, 0, 16'h003A, 4);
    // writebacks: busy, non-busy, R0
    tbl[17] = mk(0, AD, 0, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0038, 3);
    tbl[18] = mk(0, AD, 0, 0, 0, 0, 1, 6, 0, 0, 0, 16'h0038, 3);
    tbl[19] = mk(0, AD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0038, 3);
    // R6 reissue around its own writeback; ADDI ignores sr2
    tbl[20] = mk(1, LD, 1, 6, 0, 0, 0, 0, 0, 0, 0, 16'h0078, 4);
    tbl[21] = mk(1, LD, 1, 6, 0, 0, 1, 6, 0, 0, 1, 16'h0038, 3);
    tbl[22] = mk(1, LD, 1, 6, 0, 0, 0, 0, 0, 0, 0, 16'h0078, 4);
    tbl[23] = mk(1, AD, 1, 7, 0, 6, 0, 0, 0, 0, 0, 16'h0078, 4);
    tbl[24] = mk(0, AD, 0, 0, 0, 0, 1, 3, 0, 0, 0, 16'h0070, 3);
    tbl[25] = mk(1, LD, 1, 7, 0, 0, 1, 4, 0, 0, 0, 16'h00E0, 3);

    #1;
    chk("reset_busy", bus.o_busy, 16'h0);
    chk("reset_outstanding", bus.o_outstanding, 0);
    chk("reset_deadlock", bus.o_deadlock, 0);
    chk("reset_hazard", bus.o_hazard, 0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #2;
      chk($sformatf("vec%0d_hazard", i), bus.o_hazard, tbl[i].eh);
      chk($sformatf("vec%0d_pstall", i), bus.o_pipe_stall,
          tbl[i].eh | tbl[i].ps);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_busy", i), bus.o_busy, tbl[i].eb);
      chk($sformatf("vec%0d_out", i), bus.o_outstanding, tbl[i].eo);
    end

    // RAW on R5, never written back
    drive(mk(1, AD, 1, 8, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("dl_hazard", bus.o_hazard, 1);
    for (int i = 1; i <= 256; i++) begin
      @(posedge clk);
      #1;
      if (i == 255) chk("dl_before", bus.o_deadlock, 0);
      if (i == 256) chk("dl_set", bus.o_deadlock, 1);
    end
    @(posedge clk);
    #1;
    chk("dl_sticky", bus.o_deadlock, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.o_busy, 16'h0);
    chk("arst_out", bus.o_outstanding, 0);
    chk("arst_deadlock", bus.o_deadlock, 0);
    chk("arst_hazard", bus.o_hazard, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    q_pend.delete();
    dl_run = 0;
    m_dead = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int sel;
      t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      t.valid = ($urandom_range(9) < 8);
      sel = int'($urandom_range(9));
      t.op  = (sel < 5) ? LD : (sel < 6) ? BR : 5'($urandom_range(31));
      t.ri  = 1'($urandom_range(1));
      t.dr  = 4'($urandom_range(7));
      t.sr1 = 4'($urandom_range(9));
      t.sr2 = 4'($urandom_range(9));
      t.wbv = ($urandom_range(9) < 4);
      if (q_pend.size() > 0 && $urandom_range(3) != 0)
        t.wbr = 4'(q_pend[$urandom_range(q_pend.size() - 1)]);
      else
        t.wbr = 4'($urandom_range(15));
      t.ps = ($urandom_range(7) == 0);
      t.fl = ($urandom_range(9) == 0);
      drive(t);
      h = m_hazard(t);
      #2;
      chk("rnd_hazard", bus.o_hazard, h);
      chk("rnd_pstall", bus.o_pipe_stall, h | t.ps);
      m_step(t, h);
      @(posedge clk);
      #1;
      chk("rnd_busy", bus.o_busy, m_busy());
      chk("rnd_out", bus.o_outstanding, q_pend.size());
      chk("rnd_deadlock", bus.o_deadlock, m_dead);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
